// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Two-port arbiter and sequencer for an external asynchronous SRAM.
// Port 0 is the CPU, port 1 is video/loader. One transaction owns the bus at a
// time; the block generates CE/OE/WE and drives the bidirectional pad bank via
// dq_out/dq_oe. Every transaction ends with a DONE cycle and then an IDLE cycle,
// both with oe_n=1 and dq_oe=0, so the FPGA and the SRAM never drive together.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds all four
// stable until ackN pulses for one cycle. It drops reqN on the edge where ackN
// is seen, so reqN is low in the IDLE cycle that follows DONE. Requests are only
// sampled in IDLE; both pending -> the port that was not granted last wins.
module sram_bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    input  logic [DATA_W-1:0] dq_in,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WS   = 3'd2,
        S_WP   = 3'd3,
        S_WH   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state;
    logic [2:0]  wait_cnt;
    logic        last_grant;
    logic        gnt_port;

    logic              pick_valid;
    logic              pick_port;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    assign state_dbg = state;

    // Round-robin choice among the requests seen in the current cycle.
    always_comb begin
        pick_valid = req0 | req1;
        pick_port  = 1'b0;
        if (req0 && req1) begin
            pick_port = ~last_grant;
        end else begin
            pick_port = req1;
        end
        pick_we    = pick_port ? we1    : we0;
        pick_addr  = pick_port ? addr1  : addr0;
        pick_wdata = pick_port ? wdata1 : wdata0;
    end

    // Sequencer: every output is a register set for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= 3'd0;
            last_grant <= 1'b1;
            gnt_port   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            dq_out     <= '0;
            dq_oe      <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt_port   <= pick_port;
                        last_grant <= pick_port;
                        sram_addr  <= pick_addr;
                        sram_ce_n  <= 1'b0;
                        if (pick_we) begin
                            dq_out <= pick_wdata;
                            dq_oe  <= 1'b1;
                            state  <= S_WS;
                        end else begin
                            sram_oe_n <= 1'b0;
                            wait_cnt  <= 3'(RD_WAIT);
                            state     <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (wait_cnt == 3'd0) begin
                        rdata     <= dq_in;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        ack0      <= ~gnt_port;
                        ack1      <= gnt_port;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_WS: begin
                    sram_we_n <= 1'b0;
                    wait_cnt  <= 3'(WR_WAIT);
                    state     <= S_WP;
                end
                S_WP: begin
                    if (wait_cnt == 3'd0) begin
                        sram_we_n <= 1'b1;
                        state     <= S_WH;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_WH: begin
                    dq_oe     <= 1'b0;
                    sram_ce_n <= 1'b1;
                    ack0      <= ~gnt_port;
                    ack1      <= gnt_port;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    dq_oe     <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter
// Drives both ports with directed and random transactions against a behavioural
// asynchronous SRAM. Expected responses come from a reference memory updated in
// program order per port; a negedge monitor scores acks and bus-protocol rules.
module tb_sram_bus_arbiter;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int RD_WAIT = 1;
    localparam int WR_WAIT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic              we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n, sram_oe_n, sram_we_n;
    logic [DATA_W-1:0] dq_out;
    logic              dq_oe;
    logic [DATA_W-1:0] dq_in;
    logic [2:0]        state_dbg;

    logic [DATA_W-1:0] sram_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem  [0:(1<<ADDR_W)-1];

    // bit DATA_W = 1 for read, low bits = expected read data
    logic [DATA_W:0]   exp_q0[$];
    logic [DATA_W:0]   exp_q1[$];
    logic              ack_order[$];
    logic [DATA_W-1:0] model_last;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sram_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- behavioural asynchronous SRAM ----------------
    assign dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'hEE;
    initial forever begin
        @(negedge clk);
        if (rst_n && !sram_ce_n && !sram_we_n && dq_oe) sram_mem[sram_addr] = dq_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic score(input int p);
        logic [DATA_W:0] e;
        if (p == 0) begin
            if (exp_q0.size() == 0) begin check("unexpected_ack0", 1, 0); return; end
            e = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() == 0) begin check("unexpected_ack1", 1, 0); return; end
            e = exp_q1.pop_front();
        end
        ack_order.push_back(1'(p));
        if (e[DATA_W]) begin
            check(p == 0 ? "rdata_p0" : "rdata_p1", 32'(rdata), 32'(e[DATA_W-1:0]));
            model_last = e[DATA_W-1:0];
        end else begin
            check("rdata_hold_on_write", 32'(rdata), 32'(model_last));
        end
    endtask

    // ---------------- monitor ----------------
    int hi_run = 2, oe_run = 0, dq_run = 0, we_run = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hi_run = 2; oe_run = 0; dq_run = 0; we_run = 0;
            model_last = '0;
        end else begin
            if (!sram_oe_n) check("oe_while_fpga_drives", 32'(dq_oe), 0);
            if (!sram_we_n) check("we_outside_write", {30'd0, sram_ce_n, dq_oe}, 32'b01);
            if (sram_ce_n) begin
                check("idle_bus_strobes", {29'd0, sram_oe_n, sram_we_n, dq_oe}, 32'b110);
                hi_run++;
            end else begin
                if (hi_run > 0) check("turnaround_gap", 32'(hi_run >= 2), 1);
                hi_run = 0;
            end
            if (!sram_oe_n) oe_run++;
            else if (oe_run > 0) begin
                check("read_strobe_len", oe_run, RD_WAIT + 1);
                oe_run = 0;
            end
            if (dq_oe) begin
                dq_run++;
                if (!sram_we_n) we_run++;
            end else if (dq_run > 0) begin
                check("write_drive_len", dq_run, WR_WAIT + 3);
                check("we_pulse_len", we_run, WR_WAIT + 1);
                dq_run = 0; we_run = 0;
            end
            if (ack0 && ack1) check("single_ack", 1, 0);
            if (ack0) score(0);
            if (ack1) score(1);
        end
    end

    // ---------------- driver ----------------
    task automatic txn(input int p, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input int lat_exp);
        int start;
        bit got;
        @(posedge clk);
        #1;
        if (wr) ref_mem[a] = d;
        if (p == 0) begin
            exp_q0.push_back({~wr, wr ? 8'h00 : ref_mem[a]});
            we0 = wr; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            exp_q1.push_back({~wr, wr ? 8'h00 : ref_mem[a]});
            we1 = wr; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
        start = cyc;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if ((p == 0) ? ack0 : ack1) got = 1'b1;
        end
        if (!got) check("ack_timeout", 0, 1);
        else if (lat_exp > 0) check(wr ? "write_latency" : "read_latency", cyc - start, lat_exp);
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_txn(input int p);
        logic [3:0]        r;
        logic              wr;
        logic [DATA_W-1:0] d;
        r  = 4'($urandom_range(0, 15));
        wr = 1'($urandom_range(0, 1));
        d  = 8'($urandom);
        txn(p, wr, {1'(p), 11'd0, r}, d, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int base;
    bit hit;
    initial begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                logic [ADDR_W-1:0] a;
                logic [DATA_W-1:0] v;
                a = {1'(p), 11'd0, 4'(i)};
                v = 8'($urandom);
                sram_mem[a] = v;
                ref_mem[a]  = v;
            end
        end
        sram_mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
        sram_mem[16'h0200] = 8'h00; ref_mem[16'h0200] = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", {26'd0, sram_ce_n, sram_oe_n, sram_we_n, dq_oe, ack0, ack1}, 32'b111000);
        check("reset_rdata", 32'(rdata), 0);
        check("reset_addr", 32'(sram_addr), 0);
        check("reset_dq_out", 32'(dq_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed read, write, read-after-write
        txn(0, 1'b0, 16'h1234, 8'h00, RD_WAIT + 2);
        check("read_1234_value", 32'(rdata), 32'h A5);
        txn(1, 1'b1, 16'h0200, 8'h3C, WR_WAIT + 4);
        check("write_keeps_rdata", 32'(rdata), 32'hA5);
        txn(1, 1'b0, 16'h0200, 8'h00, RD_WAIT + 2);
        check("readback_0200", 32'(rdata), 32'h3C);

        // both ports from reset, continuously: order 0,1,0,1,0,1
        do_reset();
        base = ack_order.size();
        fork
            begin for (int i = 0; i < 3; i++) rand_txn(0); end
            begin for (int i = 0; i < 3; i++) rand_txn(1); end
        join
        check("order_count", ack_order.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < ack_order.size())
                check("grant_order", 32'(ack_order[base + i]), 32'(i % 2));
        end

        // random traffic with random gaps
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    rand_txn(0);
                end
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    rand_txn(1);
                end
            end
        join

        // reset during the write pulse
        @(posedge clk);
        #1;
        we1 = 1'b1; addr1 = 16'h0300; wdata1 = 8'h77; req1 = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (!sram_we_n) hit = 1'b1;
        end
        check("reached_write_pulse", 32'(hit), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_strobes", {27'd0, sram_ce_n, sram_we_n, sram_oe_n, dq_oe, ack1}, 32'b11100);
        req1 = 1'b0;
        base = ack_order.size();
        repeat (2) @(posedge clk);
        #1;
        check("abort_reset_outputs", {26'd0, sram_ce_n, sram_oe_n, sram_we_n, dq_oe, ack0, ack1}, 32'b111000);
        check("abort_reset_rdata", 32'(rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_ack_after_abort", ack_order.size() - base, 0);
        txn(1, 1'b1, 16'h0005 | 16'h8000, 8'hC3, WR_WAIT + 4);
        txn(1, 1'b0, 16'h8005, 8'h00, RD_WAIT + 2);
        check("post_abort_readback", 32'(rdata), 32'hC3);

        repeat (4) @(posedge clk);
        check("queue0_drained", exp_q0.size(), 0);
        check("queue1_drained", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
